// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier with optional two's-complement mode.
// Operands are reduced to magnitudes, multiplied, and the sign is reapplied.
module seq_mult_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ADD_CHK,
        SHIFT,
        FINAL
    } state_t;

    state_t            state_q, state_d;
    logic [W2:0]       acc_q, acc_d;
    logic [WIDTH-1:0]  mc_q, mc_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W2-1:0]     result_q, result_d;

    logic              sgn;
    logic [WIDTH-1:0]  mp_mag;
    logic [WIDTH-1:0]  mc_mag;
    logic [WIDTH:0]    sum;
    logic              last;

    assign sgn    = SIGNED_EN && signed_mode;
    assign mp_mag = (sgn && mplier[WIDTH-1]) ? ({WIDTH{1'b0}} - mplier) : mplier;
    assign mc_mag = (sgn && mcand[WIDTH-1]) ? ({WIDTH{1'b0}} - mcand) : mcand;
    // Carry out of the partial-product add lands in acc[2W].
    assign sum    = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mc_q};
    assign last   = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        // busy spans the done cycle, which also blocks a start there.
        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (st && !busy_q) begin
                    acc_d   = {{(WIDTH + 1){1'b0}}, mp_mag};
                    mc_d    = mc_mag;
                    neg_d   = sgn && (mplier[WIDTH-1] ^ mcand[WIDTH-1]);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD_CHK;
                end
            end
            ADD_CHK: begin
                if (acc_q[0]) begin
                    acc_d[W2:WIDTH] = sum;
                    state_d         = SHIFT;
                end else begin
                    acc_d   = acc_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last ? FINAL : ADD_CHK;
                end
            end
            SHIFT: begin
                acc_d   = acc_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? FINAL : ADD_CHK;
            end
            FINAL: begin
                result_d = neg_q ? ({W2{1'b0}} - acc_q[W2-1:0])
                                 : acc_q[W2-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mc_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: a signed-capable and an unsigned-only instance
// share stimulus; expected products are queued at start, popped at done.
module tb_seq_mult_param;

    logic        clk;
    logic        rst;
    logic        st;
    logic        signed_mode;
    logic [7:0]  mplier;
    logic [7:0]  mcand;
    logic        busy_s, done_s, busy_u, done_u;
    logic [15:0] result_s, result_u;

    int nvec;
    int nerr;
    logic [15:0] exp_q[$];

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .st(st), .signed_mode(signed_mode),
        .mplier(mplier), .mcand(mcand),
        .busy(busy_s), .done(done_s), .result(result_s)
    );

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .st(st), .signed_mode(signed_mode),
        .mplier(mplier), .mcand(mcand),
        .busy(busy_u), .done(done_u), .result(result_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cur_done(input bit u);
        return u ? done_u : done_s;
    endfunction

    function automatic logic cur_busy(input bit u);
        return u ? busy_u : busy_s;
    endfunction

    function automatic logic [15:0] cur_res(input bit u);
        return u ? result_u : result_s;
    endfunction

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input bit s);
        int x, y;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return 16'(x * y);
    endfunction

    function automatic int model_lat(input logic [7:0] a, input bit s);
        int x;
        logic [7:0] m;
        x = s ? int'($signed(a)) : int'(a);
        m = 8'(x < 0 ? -x : x);
        return 8 + $countones(m) + 1;
    endfunction

    task automatic do_op(input logic [7:0] mp, input logic [7:0] mc,
                         input logic sm, input bit u, input string tag);
        logic [15:0] prev;
        logic [15:0] exp;
        int lat, n;
        bit bad;
        prev = cur_res(u);
        exp_q.push_back(model(mp, mc, sm && !u));
        lat = model_lat(mp, sm && !u);
        mplier = mp; mcand = mc; signed_mode = sm; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        mplier = ~mp;
        mcand = ~mc;
        nvec++;
        if (cur_res(u) !== prev) begin
            nerr++;
            $display("FAIL %s held: got %h want %h", tag, cur_res(u), prev);
        end
        n = 0;
        bad = 1'b0;
        while (!cur_done(u) && n < 40) begin
            if (cur_busy(u) !== 1'b1) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        nvec++;
        if (n !== lat) begin
            nerr++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, lat);
        end
        nvec++;
        if (cur_res(u) !== exp) begin
            nerr++;
            $display("FAIL %s result: got %h want %h", tag, cur_res(u), exp);
        end
        nvec++;
        if (bad || cur_busy(u) !== 1'b1) begin
            nerr++;
            $display("FAIL %s busy-during: got %b want 1", tag, cur_busy(u));
        end
        @(negedge clk);
        nvec++;
        if (cur_done(u) !== 1'b0 || cur_busy(u) !== 1'b0) begin
            nerr++;
            $display("FAIL %s after-done: got done=%b busy=%b want 0 0",
                     tag, cur_done(u), cur_busy(u));
        end
    endtask

    task automatic test_reset();
        nvec++;
        if (busy_s !== 1'b0 || busy_u !== 1'b0) begin
            nerr++;
            $display("FAIL reset busy: got %b %b want 0 0", busy_s, busy_u);
        end
        nvec++;
        if (done_s !== 1'b0 || done_u !== 1'b0) begin
            nerr++;
            $display("FAIL reset done: got %b %b want 0 0", done_s, done_u);
        end
        nvec++;
        if (result_s !== 16'h0 || result_u !== 16'h0) begin
            nerr++;
            $display("FAIL reset result: got %h %h want 0", result_s, result_u);
        end
    endtask

    task automatic test_unsigned();
        do_op(8'd3, 8'd5, 1'b0, 1'b0, "u_3x5");
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, "u_ffxff");
        do_op(8'h00, 8'hAB, 1'b0, 1'b0, "u_0xab");
    endtask

    task automatic test_signed();
        do_op(8'hFD, 8'd7, 1'b1, 1'b0, "s_m3x7");
        do_op(8'h80, 8'h80, 1'b1, 1'b0, "s_minxmin");
        do_op(8'h7F, 8'h80, 1'b1, 1'b0, "s_maxxmin");
        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
        end
    endtask

    task automatic test_unsigned_param();
        do_op(8'hFD, 8'd7, 1'b1, 1'b1, "nosign_fdx7");
    endtask

    task automatic test_collision();
        int n, extra;
        logic [15:0] exp;
        exp_q.push_back(model(8'd5, 8'd6, 1'b0));
        mplier = 8'd5; mcand = 8'd6; signed_mode = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        n = 0;
        while (!done_s && n < 40) begin
            if (n == 3) begin
                st = 1'b1;
                mplier = 8'd9;
            end else begin
                st = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        nvec++;
        if (n !== 11) begin
            nerr++;
            $display("FAIL coll latency: got %0d want 11", n);
        end
        nvec++;
        if (result_s !== exp) begin
            nerr++;
            $display("FAIL coll result: got %h want %h", result_s, exp);
        end
        st = 1'b1;
        mplier = 8'd9;
        @(negedge clk);
        st = 1'b0;
        nvec++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            nerr++;
            $display("FAIL coll done-cycle st: got busy=%b done=%b want 0 0",
                     busy_s, done_s);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_s || busy_s) extra++;
        end
        nvec++;
        if (extra !== 0) begin
            nerr++;
            $display("FAIL coll extra activity: got %0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        logic [15:0] exp;
        exp_q.push_back(model(8'd2, 8'd3, 1'b0));
        exp_q.push_back(model(8'd2, 8'd3, 1'b0));
        mplier = 8'd2; mcand = 8'd3; signed_mode = 1'b0; st = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        nvec++;
        if (n !== 10 || result_s !== exp) begin
            nerr++;
            $display("FAIL b2b first: got lat=%0d res=%h want 10 %h", n, result_s, exp);
        end
        @(negedge clk);
        gap = 1;
        while (!done_s && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        st = 1'b0;
        exp = exp_q.pop_front();
        nvec++;
        if (gap !== 12 || result_s !== exp) begin
            nerr++;
            $display("FAIL b2b restart: got gap=%0d res=%h want 12 %h", gap, result_s, exp);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (busy_s !== 1'b0) begin
            nerr++;
            $display("FAIL b2b drain busy: got %b want 0", busy_s);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        exp_q.push_back(model(8'd5, 8'd6, 1'b0));
        mplier = 8'd5; mcand = 8'd6; signed_mode = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        nvec++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || result_s !== 16'h0) begin
            nerr++;
            $display("FAIL midreset: got busy=%b done=%b res=%h want 0 0 0000",
                     busy_s, done_s, result_s);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_s) seen++;
        end
        nvec++;
        if (seen !== 0) begin
            nerr++;
            $display("FAIL midreset stray done: got %0d want 0", seen);
        end
        do_op(8'd2, 8'd2, 1'b0, 1'b0, "post_reset_2x2");
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        st = 1'b0;
        signed_mode = 1'b0;
        mplier = 8'h0;
        mcand = 8'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_unsigned();
        test_signed();
        test_unsigned_param();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
